// File: rtl/avalon_wait_ram.sv
// Avalon-MM responder RAM with a fixed number of wait states per transfer and a
// synchronous preload port used to load programs before the CPU is released.
module avalon_wait_ram #(
   parameter int ADDR_W      = 6,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        waitrequest,
   input  logic        inst_input,
   input  logic [7:0]  inst_addr,
   input  logic [31:0] instruction,
   output logic [1:0]  dbg_state_o
);

   localparam int         DEPTH     = 2 ** ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [31:0]         readdata_q;
   logic                rd_load;
   logic                ack_write;
   logic                req;
   logic [31:0]         inst_ext;
   logic [ADDR_W-1:0]   req_idx;
   logic [ADDR_W-1:0]   pre_idx;
   logic [31:0]         mem_q [DEPTH];
   logic                unused_bits;

   assign req      = read | write;
   assign inst_ext = {24'd0, inst_addr};
   assign req_idx  = address[ADDR_W+1:2];
   assign pre_idx  = inst_ext[ADDR_W+1:2];

   assign unused_bits = ^{address[31:ADDR_W+2], address[1:0],
                          inst_ext[31:ADDR_W+2], inst_ext[1:0]};

   // ACK is the only state in which a pending request is released to the master.
   assign waitrequest = reset | inst_input | (req & (state_q != S_ACK));
   assign readdata    = readdata_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      rd_load   = 1'b0;
      ack_write = 1'b0;
      if (inst_input) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  addr_d = req_idx;
                  wr_d   = write;
                  if (WAIT_CYCLES == 0) begin
                     state_d = S_ACK;
                     rd_load = ~write;
                  end else begin
                     cnt_d   = WAIT_INIT;
                     state_d = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!req) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_d = S_ACK;
                     rd_load = ~wr_q;
                  end
               end
            end
            S_ACK: begin
               ack_write = wr_q;
               state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         readdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         if (rd_load) begin
            readdata_q <= mem_q[addr_d];
         end
      end
   end

   // Memory has no reset; writes are suppressed while reset is held so an aborted write is lost.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (inst_input) begin
            mem_q[pre_idx] <= instruction;
         end else if (ack_write) begin
            for (int i = 0; i < 4; i++) begin
               if (byteenable[i]) begin
                  mem_q[addr_q][8*i +: 8] <= writedata[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench for avalon_wait_ram: one instance with 1 wait state, one with 3.
module tb_avalon_wait_ram;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic        bus_rd, bus_wr;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        inst_input;
   logic [7:0]  inst_addr;
   logic [31:0] instruction;
   logic        sel;

   logic        rd1, wr1, rd3, wr3;
   logic [31:0] rdata1, rdata3, rdata;
   logic        wreq1, wreq3, wreq;
   logic [1:0]  st1, st3, st;

   logic [31:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   assign rd1   = bus_rd & ~sel;
   assign wr1   = bus_wr & ~sel;
   assign rd3   = bus_rd & sel;
   assign wr3   = bus_wr & sel;
   assign rdata = sel ? rdata3 : rdata1;
   assign wreq  = sel ? wreq3 : wreq1;
   assign st    = sel ? st3 : st1;

   avalon_wait_ram #(.ADDR_W(6), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .address(address), .read(rd1), .write(wr1),
      .writedata(writedata), .byteenable(byteenable), .readdata(rdata1),
      .waitrequest(wreq1), .inst_input(inst_input), .inst_addr(inst_addr),
      .instruction(instruction), .dbg_state_o(st1)
   );

   avalon_wait_ram #(.ADDR_W(6), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .address(address), .read(rd3), .write(wr3),
      .writedata(writedata), .byteenable(byteenable), .readdata(rdata3),
      .waitrequest(wreq3), .inst_input(inst_input), .inst_addr(inst_addr),
      .instruction(instruction), .dbg_state_o(st3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Entered and left at posedge+1; the master holds its request until waitrequest drops.
   task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] data, output int waits);
      bit done;
      done       = 1'b0;
      waits      = 0;
      data       = '0;
      address    = addr;
      bus_rd     = rd;
      bus_wr     = wr;
      writedata  = wd;
      byteenable = be;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!wreq) begin
            done = 1'b1;
            data = rdata;
         end else begin
            waits++;
         end
      end
      chk("xfer_done", {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
      bus_rd = 1'b0;
      bus_wr = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp, input int exp_waits);
      logic [31:0] d;
      int          w;
      exp_q.push_back(exp);
      xfer(1'b1, 1'b0, addr, 32'd0, 4'd0, d, w);
      chk({tag, "_data"}, d, exp_q.pop_front());
      chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      inst_input  = 1'b1;
      inst_addr   = a;
      instruction = d;
      @(negedge clk);
      chk("preload_wreq", {31'd0, wreq}, 32'd1);
      @(posedge clk);
      #1;
      inst_input = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          w;
      reset = 1'b1; address = '0; bus_rd = 1'b0; bus_wr = 1'b0;
      writedata = '0; byteenable = '0; inst_input = 1'b0; inst_addr = '0;
      instruction = '0; sel = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_wreq1", {31'd0, wreq1}, 32'd1);
      chk("reset_wreq3", {31'd0, wreq3}, 32'd1);
      chk("reset_rdata", rdata1, 32'd0);
      chk("reset_state", {30'd0, st1}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_wreq", {31'd0, wreq1}, 32'd0);
      @(posedge clk);
      #1;

      // preload then read with one wait state
      preload(8'h04, 32'h24020069);
      read_check("pre_read", 32'h04, 32'h24020069, 2);

      // single-lane write merges into existing word
      preload(8'h08, 32'hFFFFFFFF);
      xfer(1'b0, 1'b1, 32'h08, 32'h000000AA, 4'b0001, d, w);
      chk("lane_write_waits", 32'(w), 32'd2);
      chk("write_keeps_rdata", rdata1, 32'h24020069);
      read_check("lane_read", 32'h08, 32'hFFFFFFAA, 2);

      // write dropped while waiting
      preload(8'h0C, 32'h11111111);
      address = 32'h0C; writedata = 32'h12345678; byteenable = 4'hF; bus_wr = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("drop_in_wait", {30'd0, st1}, 32'd1);
      bus_wr = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("drop_to_idle", {30'd0, st1}, 32'd0);
      @(posedge clk);
      #1;
      read_check("drop_read", 32'h0C, 32'h11111111, 2);

      // reset asserted while a write waits
      preload(8'h10, 32'hA5A5A5A5);
      address = 32'h10; writedata = 32'hCAFEF00D; byteenable = 4'hF; bus_wr = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_wait_wreq", {31'd0, wreq1}, 32'd1);
      chk("rst_wait_rdata", rdata1, 32'd0);
      chk("rst_wait_state", {30'd0, st1}, 32'd0);
      bus_wr = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      read_check("rst_read", 32'h10, 32'hA5A5A5A5, 2);

      // address wraps modulo depth
      xfer(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 4'hF, d, w);
      read_check("wrap_read", 32'h04, 32'hDEADBEEF, 2);

      // read and write together: write wins, readdata untouched
      preload(8'h14, 32'h00000000);
      xfer(1'b1, 1'b1, 32'h14, 32'h00000055, 4'hF, d, w);
      chk("rw_keeps_rdata", rdata1, 32'hDEADBEEF);
      read_check("rw_read", 32'h14, 32'h00000055, 2);

      // byteenable zero completes but changes nothing
      xfer(1'b0, 1'b1, 32'h04, 32'h99999999, 4'h0, d, w);
      chk("be0_waits", 32'(w), 32'd2);
      read_check("be0_read", 32'h04, 32'hDEADBEEF, 2);

      // three wait states, back-to-back reads each pay full latency
      preload(8'h00, 32'h0BADCAFE);
      sel = 1'b1;
      read_check("w3_first", 32'h00, 32'h0BADCAFE, 4);
      read_check("w3_second", 32'h00, 32'h0BADCAFE, 4);
      sel = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
